// File: rtl/seg7_mmio_display.sv
// Memory-mapped multi-digit seven-segment display controller: two-word register
// window (DATA, CTRL), refresh scan, blink, halt dash pattern, active-low drive.
module seg7_mmio_display #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0800
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rd,
  input  logic [3:0]            we,
  input  logic [31:0]           addr,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  input  logic                  halt,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int unsigned SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic                  sel;
  logic [31:0]           data_reg;
  logic                  ctrl_en;
  logic                  ctrl_blink;
  logic [7:0]            dp_mask;
  logic [31:0]           ctrl_word;
  logic [SW-1:0]         scan_cnt;
  logic [IW-1:0]         idx;
  logic [BW-1:0]         blink_cnt;
  logic                  phase;
  logic                  step;
  logic [3:0]            nibble;
  logic [NUM_DIGITS-1:0] an_lit;
  logic                  dp_bit;
  logic [6:0]            glyph;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];
  assign sel       = (addr[31:3] == BASE_ADDR[31:3]);
  assign ctrl_word = {16'h0000, dp_mask, 6'b000000, ctrl_blink, ctrl_en};
  assign step      = (scan_cnt == SW'(REFRESH_DIV - 1));

  // Register file and read port; a same-cycle read sees the pre-write value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_reg   <= '0;
      ctrl_en    <= 1'b1;
      ctrl_blink <= 1'b0;
      dp_mask    <= '0;
      data_out   <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i] && sel && !addr[2])
          data_reg[8*i +: 8] <= data_in[8*i +: 8];
      end
      if (we[0] && sel && addr[2])
        {ctrl_blink, ctrl_en} <= data_in[1:0];
      if (we[1] && sel && addr[2])
        dp_mask <= data_in[15:8];
      data_out <= (rd && sel) ? (addr[2] ? ctrl_word : data_reg) : '0;
    end
  end

  // Scan and blink timing run independently of the enable bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      scan_cnt  <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else begin
      scan_cnt <= step ? '0 : scan_cnt + SW'(1);
      if (step) begin
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
        if (blink_cnt == BW'(BLINK_DIV - 1)) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  always_comb begin
    nibble = '0;
    an_lit = '1;
    dp_bit = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nibble    = data_reg[4*k +: 4];
        an_lit[k] = 1'b0;
        dp_bit    = ~dp_mask[k];
      end
    end
  end

  always_comb begin
    glyph = 7'h7F;
    case (nibble)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      seg <= 7'h7F;
      an  <= '1;
      dp  <= 1'b1;
    end else if (halt) begin
      seg <= 7'h3F;
      an  <= an_lit;
      dp  <= 1'b1;
    end else if (!ctrl_en || (ctrl_blink && !phase)) begin
      seg <= 7'h7F;
      an  <= '1;
      dp  <= 1'b1;
    end else begin
      seg <= glyph;
      an  <= an_lit;
      dp  <= dp_bit;
    end
  end

endmodule

// File: tb/tb_seg7_mmio_display.sv
// Bench for seg7_mmio_display: register vectors with a read scoreboard, plus
// scan, blink, halt and reset sequences against a cycle-count display model.
module tb_seg7_mmio_display;

  localparam logic [31:0] BASE = 32'h0000_0800;

  logic        clk = 1'b0;
  logic        rstn, rd, halt;
  logic [3:0]  we;
  logic [31:0] addr, data_in, data_out;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  logic        f_rd, f_halt;
  logic [3:0]  f_we;
  logic [31:0] f_addr, f_data_in, f_data_out;
  logic [6:0]  f_seg;
  logic        f_dp;
  logic [3:0]  f_an;

  always #5 clk = ~clk;

  seg7_mmio_display #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_DIV(2), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rstn(rstn), .rd(rd), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .halt(halt), .seg(seg), .dp(dp), .an(an)
  );

  seg7_mmio_display #(.NUM_DIGITS(4), .REFRESH_DIV(1), .BLINK_DIV(2), .BASE_ADDR(BASE)) u_fast (
    .clk(clk), .rstn(rstn), .rd(f_rd), .we(f_we), .addr(f_addr), .data_in(f_data_in),
    .data_out(f_data_out), .halt(f_halt), .seg(f_seg), .dp(f_dp), .an(f_an)
  );

  // Edges since reset release; drives the expected scan position.
  int rel_cyc = 0;
  always @(posedge clk) rel_cyc <= rstn ? rel_cyc + 1 : 0;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    string       name;
    logic [31:0] waddr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  logic [6:0]  glyph[16];
  logic [31:0] m_data;
  logic [3:0]  m_dp;
  logic        m_en, m_halt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk();
    sb_t s;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      s = sbq.pop_front();
      chk(s.name, data_out, s.exp);
    end
  endtask

  task automatic exp_disp();
    logic [1:0] d;
    logic [3:0] ea, nib;
    logic [6:0] es;
    logic       ed;
    d  = 2'(((rel_cyc - 1) / 4) % 4);
    ea = 4'hF;
    es = 7'h7F;
    ed = 1'b1;
    if (m_halt) begin
      ea[d] = 1'b0;
      es    = 7'h3F;
    end else if (m_en) begin
      ea[d] = 1'b0;
      nib   = 4'(m_data >> {d, 2'b00});
      es    = glyph[nib];
      ed    = ~m_dp[d];
    end
    chk($sformatf("an d%0d", d), {28'b0, an}, {28'b0, ea});
    chk($sformatf("seg d%0d", d), {25'b0, seg}, {25'b0, es});
    chk($sformatf("dp d%0d", d), {31'b0, dp}, {31'b0, ed});
  endtask

  task automatic disp_run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      exp_disp();
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    addr = a; we = w; data_in = d; rd = 1'b0;
    tick();
    we = 4'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        vis;
    logic [1:0]  fd;
    logic [3:0]  fa;
    logic [31:0] w;

    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0] = '{"data_word",    BASE,          4'hF, 32'h1234_5678, BASE,          32'h1234_5678};
    vecs[1] = '{"data_byte1",   BASE,          4'h2, 32'h0000_3300, BASE,          32'h1234_3378};
    vecs[2] = '{"data_byte3_a", BASE + 32'd3,  4'h8, 32'hAB00_0000, BASE,          32'hAB34_3378};
    vecs[3] = '{"ctrl_all",     BASE + 32'd4,  4'hF, 32'hFFFF_FFFF, BASE + 32'd4,  32'h0000_FF03};
    vecs[4] = '{"ctrl_byte0",   BASE + 32'd4,  4'h1, 32'h0000_0000, BASE + 32'd4,  32'h0000_FF00};
    vecs[5] = '{"unmapped_rd",  BASE + 32'd8,  4'hF, 32'hDEAD_BEEF, BASE + 32'd8,  32'h0000_0000};
    vecs[6] = '{"unmapped_wr",  BASE + 32'd8,  4'hF, 32'h0000_0000, BASE,          32'hAB34_3378};
    vecs[7] = '{"alias_wr",     32'h0000_1800, 4'hF, 32'h0000_0000, BASE,          32'hAB34_3378};
    vecs[8] = '{"ctrl_dp",      BASE + 32'd4,  4'hF, 32'h0000_0501, BASE + 32'd4,  32'h0000_0501};
    vecs[9] = '{"data_a18f",    BASE,          4'hF, 32'h0000_A18F, BASE,          32'h0000_A18F};

    rstn = 1'b0; rd = 1'b0; we = 4'h0; addr = '0; data_in = '0; halt = 1'b0;
    f_rd = 1'b0; f_we = 4'h0; f_addr = '0; f_data_in = '0; f_halt = 1'b0;
    m_data = '0; m_dp = '0; m_en = 1'b1; m_halt = 1'b0;
    repeat (3) tick();
    chk("reset seg", {25'b0, seg}, 32'h7F);
    chk("reset an", {28'b0, an}, 32'hF);
    chk("reset dp", {31'b0, dp}, 32'h1);
    chk("reset data_out", data_out, 32'h0);
    chk("reset fast an", {28'b0, f_an}, 32'hF);

    // Release; the fast instance gets blink+enable on the first edge.
    rstn = 1'b1;
    f_we = 4'hF; f_addr = BASE + 32'd4; f_data_in = 32'h0000_0003;
    for (int t = 0; t < 20; t++) begin
      tick();
      f_we = 4'h0;
      exp_disp();
      vis = ((((rel_cyc - 1) / 2) % 2) == 0);
      fd  = 2'((rel_cyc - 1) % 4);
      fa  = 4'hF;
      if (vis) fa[fd] = 1'b0;
      chk($sformatf("blink an r%0d", rel_cyc), {28'b0, f_an}, {28'b0, fa});
      chk($sformatf("blink seg r%0d", rel_cyc), {25'b0, f_seg}, vis ? 32'h40 : 32'h7F);
    end
    f_rd = 1'b1;
    tick();
    f_rd = 1'b0;
    chk("fast ctrl read", f_data_out, 32'h0000_0003);

    addr = BASE + 32'd4; rd = 1'b1;
    sbq.push_back('{"ctrl_reset_rd", 32'h0000_0001});
    tick();
    rd = 1'b0;
    pop_chk();

    foreach (vecs[i]) begin
      bus_write(vecs[i].waddr, vecs[i].we, vecs[i].wdata);
      addr = vecs[i].raddr; rd = 1'b1;
      sbq.push_back('{vecs[i].name, vecs[i].exp});
      tick();
      rd = 1'b0;
      pop_chk();
    end
    tick();
    chk("rd_drop", data_out, 32'h0);

    m_data = 32'h0000_A18F; m_dp = 4'b0101; m_en = 1'b1;
    disp_run(16);

    for (int g = 0; g < 4; g++) begin
      w = '0;
      for (int j = 0; j < 4; j++) w[4*j +: 4] = 4'(4 * g + j);
      bus_write(BASE, 4'hF, w);
      m_data = w;
      disp_run(16);
    end

    bus_write(BASE + 32'd4, 4'hF, 32'h0);
    m_en = 1'b0; m_dp = 4'h0;
    disp_run(8);
    halt = 1'b1; m_halt = 1'b1;
    disp_run(8);
    halt = 1'b0; m_halt = 1'b0;
    disp_run(4);

    // Same-cycle read and write returns the old word.
    addr = BASE; rd = 1'b1; we = 4'hF; data_in = 32'h5555_5555;
    sbq.push_back('{"rw_same_cycle", 32'h0000_FEDC});
    tick();
    we = 4'h0;
    pop_chk();
    sbq.push_back('{"rw_after", 32'h5555_5555});
    tick();
    rd = 1'b0;
    pop_chk();

    // Reset during a write discards it and restarts the scan.
    rstn = 1'b0; addr = BASE; we = 4'hF; data_in = 32'hFFFF_FFFF;
    tick();
    rstn = 1'b1; we = 4'h0; rd = 1'b1; addr = BASE;
    sbq.push_back('{"reset_mid_write_data", 32'h0});
    tick();
    pop_chk();
    addr = BASE + 32'd4;
    sbq.push_back('{"reset_mid_write_ctrl", 32'h1});
    tick();
    rd = 1'b0;
    pop_chk();
    m_data = '0; m_dp = '0; m_en = 1'b1;
    disp_run(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
